uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Parameters
REQ-001 SHALL provide DATA_BITS, default 8, number of data bits per frame (legal 5..8).
REQ-002 SHALL provide PARITY_EN, default 0, 1 inserts a parity bit after the data bits.
REQ-003 SHALL provide PARITY_ODD, default 0, 1 selects odd parity and 0 selects even (ignored when PARITY_EN=0).
REQ-004 SHALL provide STOP_BITS, default 1, number of stop bits (legal 1..2).

Interface
REQ-005 SHALL have port clk, input, 1 bit: the single system clock; all logic on posedge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port tx_signal, input, 1 bit: one-clk bit-rate tick from the baud rate generator.
REQ-008 SHALL have port tx_start, input, 1 bit: request to send tx_data.
REQ-009 SHALL have port tx_data, input, 8 bits: payload; only bits [DATA_BITS-1:0] are used.
REQ-010 SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-011 SHALL have port busy, output, 1 bit: high from accept until the frame completes.
REQ-012 SHALL have port done, output, 1 bit: one-clk pulse at frame completion.

Function
REQ-013 SHALL implement states IDLE, WAIT, START, DATA, PARITY, STOP.
REQ-014 SHALL make all outputs registered.
REQ-015 SHALL accept tx_start only when busy=0: latch tx_data into a shift register, go to WAIT, and assert busy on the next clk.
REQ-016 SHALL ignore tx_start while busy=1, with no effect on the frame in flight or on the latched data.
REQ-017 SHALL hold tx=1 in WAIT; on tx_signal go to START and drive tx=0 on the next clk.
REQ-018 SHALL change state and tx only on clks where tx_signal=1, outside IDLE/WAIT entry, so every bit lasts exactly one tick interval.
REQ-019 SHALL, in START, go to DATA on tick and drive bit0.
REQ-020 SHALL send data bits LSB first, using a bit counter of 0..DATA_BITS-1.
REQ-021 SHALL, on the tick ending the last data bit, go to PARITY if PARITY_EN=1, else go to STOP.
REQ-022 SHALL compute the parity bit as XOR of the DATA_BITS payload bits, inverted when PARITY_ODD=1.
REQ-023 SHALL drive tx=1 in STOP, counting STOP_BITS ticks.
REQ-024 SHALL, on the tick ending the last stop bit, enter IDLE; on that same next clk, busy becomes 0 and done becomes 1 for exactly one clk.
REQ-025 SHALL accept a tx_start presented in the clk where done=1 (busy=0), giving back-to-back frames with no extra idle bit.
REQ-026 SHALL count in WAIT by waiting only; no timeout applies.
REQ-027 SHALL treat a tx_signal asserted in the same clk as an accepted tx_start as not counted, so WAIT needs a later tick.
REQ-028 SHALL never let the bit counter wrap past DATA_BITS-1, and SHALL never let the stop counter exceed STOP_BITS-1.

Reset
REQ-029 SHALL, with rst=1 at posedge clk, force state=IDLE, tx=1, busy=0, done=0, and clear the counters and shift register.
REQ-030 SHALL abort an in-flight frame when rst is asserted mid-frame: tx=1 on the next clk and no done pulse.
REQ-031 SHALL give rst priority over tx_start and tx_signal in the same clk.
REQ-032 SHALL accept tx_start on the first clk after rst deasserts.

Verification
REQ-033 SHALL pass the basic frame case: tx_signal every 8 clks, defaults, tx_start with tx_data=0xA5 -> tx per tick is 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), followed by a one-clk done, with busy high throughout.
REQ-034 SHALL pass the parity case: PARITY_EN=1, PARITY_ODD=1, tx_data=0xA5 -> parity bit 1 after the data; with PARITY_ODD=0 -> parity bit 0; STOP_BITS=2 -> tx high for 2 ticks before done.
REQ-035 SHALL pass the busy-ignore case: tx_start with 0x3C while sending 0xA5 -> the 0xA5 frame is unchanged, only one done, and 0x3C is never sent.
REQ-036 SHALL pass the back-to-back case: tx_start with 0x55 in the done clk of a prior frame -> the next start bit begins on the next tick after WAIT, and both frames are correct.
REQ-037 SHALL pass the mid-frame reset case: rst asserted during data bit 3 -> next clk tx=1, busy=0, done=0; a new tx_start afterwards sends a full correct frame.
REQ-038 SHALL pass the DATA_BITS=5 case: tx_data=0xFF -> five data bits of 1, then stop, and done after 7 ticks from the start bit.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: frames tx_data as start / LSB-first data / optional parity /
// stop bits, advancing one bit per tx_signal tick from an external baud generator.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | line high, not busy, waiting for tx_start
// WAIT   | frame accepted, line high, waiting for the first counted tick
// START  | driving the start bit (0)
// DATA   | driving data bits LSB first, bit_cnt_q = index of bit on line
// PARITY | driving the parity bit
// STOP   | driving stop bit(s) (1), stop_cnt_q = index of stop bit on line
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_signal,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } state_t;

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic       ODD_INV   = (PARITY_ODD != 0);

  state_t                 state_q, state_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic                   stop_cnt_q, stop_cnt_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  // Next-state and registered-output logic; bits only advance on tx_signal.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    par_d      = par_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        // A tick in the accept clock is deliberately not looked at here,
        // so WAIT always needs a later tick before the start bit.
        if (tx_start && !busy_q) begin
          shift_d    = tx_data[DATA_BITS-1:0];
          par_d      = (^tx_data[DATA_BITS-1:0]) ^ ODD_INV;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        tx_d = 1'b1;
        if (tx_signal) begin
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (tx_signal) begin
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (tx_signal) begin
          if (bit_cnt_q == LAST_BIT) begin
            if (PARITY_EN != 0) begin
              tx_d    = par_q;
              state_d = PARITY;
            end else begin
              tx_d       = 1'b1;
              stop_cnt_d = 1'b0;
              state_d    = STOP;
            end
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (tx_signal) begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = STOP;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (tx_signal) begin
          if (stop_cnt_q == LAST_STOP) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      par_q      <= 1'b0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four parameterisations share clk, rst, tick and
// data; each has its own tx_start so frames are launched one DUT at a time.
module tb_uart_tx;

  logic       clk;
  logic       rst;
  logic       tx_signal;
  logic [7:0] tx_data;
  logic [3:0] start_r;
  logic [3:0] tx_w;
  logic [3:0] busy_w;
  logic [3:0] done_w;

  int compared   = 0;
  int mismatched = 0;

  // u0: 8N1 defaults, u1: 8 bits odd parity 2 stop, u2: 8 bits even parity, u3: 5N1
  uart_tx u0 (.clk(clk), .rst(rst), .tx_signal(tx_signal), .tx_start(start_r[0]),
              .tx_data(tx_data), .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));
  uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u1 (
              .clk(clk), .rst(rst), .tx_signal(tx_signal), .tx_start(start_r[1]),
              .tx_data(tx_data), .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));
  uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u2 (
              .clk(clk), .rst(rst), .tx_signal(tx_signal), .tx_start(start_r[2]),
              .tx_data(tx_data), .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));
  uart_tx #(.DATA_BITS(5)) u3 (
              .clk(clk), .rst(rst), .tx_signal(tx_signal), .tx_start(start_r[3]),
              .tx_data(tx_data), .tx(tx_w[3]), .busy(busy_w[3]), .done(done_w[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One-clock tick every 8 clocks, changed on negedge.
  initial begin
    tx_signal = 1'b0;
    forever begin
      repeat (7) @(negedge clk);
      tx_signal = 1'b1;
      @(negedge clk);
      tx_signal = 1'b0;
    end
  end

  // Launches (or continues) a frame on DUT idx and records tx after every tick
  // until done. got[i] is the line level after tick i (i=0 is the start bit);
  // ticks is the number of ticks from the start bit to the done tick, -1 on timeout.
  task automatic capture(input int idx, input logic [7:0] data, input bit do_start,
                         input int inj_at, input logic [7:0] inj_data,
                         input bit chain, input logic [7:0] chain_data,
                         output logic [15:0] got, output int ticks,
                         output bit busy_bad, output bit acc_busy, output bit end_ok);
    int  n;
    bit  fin;
    bit  inj_pending;
    got = '0; n = 0; fin = 0; inj_pending = 0;
    ticks = -1; busy_bad = 0; end_ok = 0;
    if (do_start) begin
      @(negedge clk);
      tx_data = data;
      start_r[idx] = 1'b1;
    end
    @(posedge clk); #1;
    start_r[idx] = 1'b0;
    acc_busy = (busy_w[idx] === 1'b1);
    for (int c = 0; c < 400 && !fin; c++) begin
      @(posedge clk); #1;
      if (inj_pending) begin
        start_r[idx] = 1'b0;
        inj_pending = 0;
      end
      if (tx_signal) begin
        if (n < 16) got[n] = tx_w[idx];
        n++;
      end
      if (done_w[idx] === 1'b1) begin
        fin = 1;
        ticks = n - 1;
        end_ok = (busy_w[idx] === 1'b0) && (tx_signal === 1'b1);
        if (chain) begin
          tx_data = chain_data;
          start_r[idx] = 1'b1;
        end
      end else begin
        if (busy_w[idx] !== 1'b1) busy_bad = 1;
        if (tx_signal && (n - 1 == inj_at)) begin
          tx_data = inj_data;
          start_r[idx] = 1'b1;
          inj_pending = 1;
        end
      end
    end
    if (fin && !chain) begin
      @(posedge clk); #1;
      end_ok = end_ok && (done_w[idx] === 1'b0) && (busy_w[idx] === 1'b0) && (tx_w[idx] === 1'b1);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start_r = 4'hF;
    tx_data = 8'hFF;
    repeat (12) @(posedge clk);
    #1;
    compared++;
    if (tx_w !== 4'hF || busy_w !== 4'h0 || done_w !== 4'h0) begin
      mismatched++;
      $display("FAIL reset_hold: tx=%b busy=%b done=%b want tx=1111 busy=0000 done=0000", tx_w, busy_w, done_w);
    end
    rst = 1'b0;
    start_r = 4'h0;
    @(posedge clk); #1;
    compared++;
    if (tx_w !== 4'hF || busy_w !== 4'h0 || done_w !== 4'h0) begin
      mismatched++;
      $display("FAIL reset_release: tx=%b busy=%b done=%b want tx=1111 busy=0000 done=0000", tx_w, busy_w, done_w);
    end
  endtask

  task automatic test_basic;
    logic [15:0] got; int ticks; bit bb, ab, eo;
    capture(0, 8'hA5, 1, -1, 8'h00, 0, 8'h00, got, ticks, bb, ab, eo);
    compared++;
    if (got[9:0] !== 10'h34A) begin
      mismatched++; $display("FAIL basic_bits: got %h want 34a", got[9:0]);
    end
    compared++;
    if (ticks !== 10) begin
      mismatched++; $display("FAIL basic_ticks: got %0d want 10", ticks);
    end
    compared++;
    if (!ab || bb || !eo) begin
      mismatched++; $display("FAIL basic_busy_done: accept_busy=%0d busy_drop=%0d end_ok=%0d want 1 0 1", ab, bb, eo);
    end
  endtask

  task automatic test_patterns;
    logic [15:0] got; int ticks; bit bb, ab, eo;
    capture(0, 8'h00, 1, -1, 8'h00, 0, 8'h00, got, ticks, bb, ab, eo);
    compared++;
    if (got[9:0] !== 10'h200 || ticks !== 10 || !eo) begin
      mismatched++; $display("FAIL pat_00: bits %h ticks %0d end_ok %0d want 200 10 1", got[9:0], ticks, eo);
    end
    capture(0, 8'hFF, 1, -1, 8'h00, 0, 8'h00, got, ticks, bb, ab, eo);
    compared++;
    if (got[9:0] !== 10'h3FE || ticks !== 10 || !eo) begin
      mismatched++; $display("FAIL pat_ff: bits %h ticks %0d end_ok %0d want 3fe 10 1", got[9:0], ticks, eo);
    end
    // upper bits beyond DATA_BITS=5 must be ignored
    capture(3, 8'hE0, 1, -1, 8'h00, 0, 8'h00, got, ticks, bb, ab, eo);
    compared++;
    if (got[6:0] !== 7'h40 || ticks !== 7 || !eo) begin
      mismatched++; $display("FAIL pat_5bit_mask: bits %h ticks %0d end_ok %0d want 40 7 1", got[6:0], ticks, eo);
    end
  endtask

  task automatic test_parity;
    logic [15:0] got; int ticks; bit bb, ab, eo;
    capture(1, 8'hA5, 1, -1, 8'h00, 0, 8'h00, got, ticks, bb, ab, eo);
    compared++;
    if (got[11:0] !== 12'hF4A || ticks !== 12 || bb || !eo) begin
      mismatched++; $display("FAIL parity_odd_2stop: bits %h ticks %0d busy_drop %0d end_ok %0d want f4a 12 0 1", got[11:0], ticks, bb, eo);
    end
    capture(2, 8'hA5, 1, -1, 8'h00, 0, 8'h00, got, ticks, bb, ab, eo);
    compared++;
    if (got[10:0] !== 11'h54A || ticks !== 11 || bb || !eo) begin
      mismatched++; $display("FAIL parity_even: bits %h ticks %0d busy_drop %0d end_ok %0d want 54a 11 0 1", got[10:0], ticks, bb, eo);
    end
    capture(1, 8'h00, 1, -1, 8'h00, 0, 8'h00, got, ticks, bb, ab, eo);
    compared++;
    if (got[11:0] !== 12'hE00 || ticks !== 12) begin
      mismatched++; $display("FAIL parity_odd_zero: bits %h ticks %0d want e00 12", got[11:0], ticks);
    end
  endtask

  task automatic test_busy_ignore;
    logic [15:0] got; int ticks; bit bb, ab, eo; int act;
    capture(0, 8'hA5, 1, 3, 8'h3C, 0, 8'h00, got, ticks, bb, ab, eo);
    compared++;
    if (got[9:0] !== 10'h34A || ticks !== 10 || bb || !eo) begin
      mismatched++; $display("FAIL busy_ignore_frame: bits %h ticks %0d busy_drop %0d end_ok %0d want 34a 10 0 1", got[9:0], ticks, bb, eo);
    end
    act = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || done_w[0] !== 1'b0) act++;
    end
    compared++;
    if (act !== 0) begin
      mismatched++; $display("FAIL busy_ignore_idle: active cycles %0d want 0", act);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] got; int ticks; bit bb, ab, eo;
    capture(0, 8'hA5, 1, -1, 8'h00, 1, 8'h55, got, ticks, bb, ab, eo);
    compared++;
    if (got[9:0] !== 10'h34A || ticks !== 10 || !eo) begin
      mismatched++; $display("FAIL b2b_first: bits %h ticks %0d end_ok %0d want 34a 10 1", got[9:0], ticks, eo);
    end
    capture(0, 8'h00, 0, -1, 8'h00, 0, 8'h00, got, ticks, bb, ab, eo);
    compared++;
    if (!ab || got[9:0] !== 10'h2AA || ticks !== 10 || bb || !eo) begin
      mismatched++; $display("FAIL b2b_second: accept_busy %0d bits %h ticks %0d busy_drop %0d end_ok %0d want 1 2aa 10 0 1", ab, got[9:0], ticks, bb, eo);
    end
  endtask

  task automatic test_mid_reset;
    logic [15:0] got; int ticks; bit bb, ab, eo; int n; logic tx_before;
    @(negedge clk);
    tx_data = 8'hA5;
    start_r[0] = 1'b1;
    @(posedge clk); #1;
    start_r[0] = 1'b0;
    n = 0;
    for (int c = 0; c < 200 && n < 5; c++) begin
      @(posedge clk); #1;
      if (tx_signal) n++;
    end
    repeat (3) @(posedge clk);
    #1;
    tx_before = tx_w[0];
    compared++;
    if (n !== 5 || tx_before !== 1'b0 || busy_w[0] !== 1'b1) begin
      mismatched++; $display("FAIL midrst_inflight: ticks %0d tx %b busy %b want 5 0 1", n, tx_before, busy_w[0]);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    compared++;
    if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || done_w[0] !== 1'b0) begin
      mismatched++; $display("FAIL midrst_abort: tx %b busy %b done %b want 1 0 0", tx_w[0], busy_w[0], done_w[0]);
    end
    rst = 1'b0;
    capture(0, 8'h5A, 1, -1, 8'h00, 0, 8'h00, got, ticks, bb, ab, eo);
    compared++;
    if (!ab || got[9:0] !== 10'h2B4 || ticks !== 10 || bb || !eo) begin
      mismatched++; $display("FAIL midrst_next: accept_busy %0d bits %h ticks %0d busy_drop %0d end_ok %0d want 1 2b4 10 0 1", ab, got[9:0], ticks, bb, eo);
    end
  endtask

  task automatic test_data5;
    logic [15:0] got; int ticks; bit bb, ab, eo;
    capture(3, 8'hFF, 1, -1, 8'h00, 0, 8'h00, got, ticks, bb, ab, eo);
    compared++;
    if (got[6:0] !== 7'h7E || ticks !== 7 || bb || !eo) begin
      mismatched++; $display("FAIL data5_ff: bits %h ticks %0d busy_drop %0d end_ok %0d want 7e 7 0 1", got[6:0], ticks, bb, eo);
    end
  endtask

  initial begin
    rst = 1'b1;
    start_r = 4'h0;
    tx_data = 8'h00;
    test_reset();
    test_basic();
    test_patterns();
    test_parity();
    test_busy_ignore();
    test_back_to_back();
    test_mid_reset();
    test_data5();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
